pcm_frame_tx: RTL and testbench
===============================

PCM_FRAME_TX -- requirements
Module: pcm_frame_tx

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 32, timeslots per frame (range 2..32).
REQ-002 SHALL have parameter BIT_DIV, default 4, clk cycles per serial bit (range 2..256).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pcm_in  input  8  companded PCM code from encoder.
REQ-006 SHALL have port pcm_valid  input  1  pcm_in valid.
REQ-007 SHALL have port pcm_ready  output  1  block accepts pcm_in this cycle.
REQ-008 SHALL have port ser_out  output  1  serial TDM bit stream, MSB first.
REQ-009 SHALL have port bit_stb  output  1  one-cycle pulse marking the cycle a new ser_out bit is presented.
REQ-010 SHALL have port frame_sync  output  1  high for the BIT_DIV cycles of bit 7 of slot 0.
REQ-011 SHALL have port slot_idx  output  5  index of the slot currently shifting.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a data slot loads idle code.

Function
REQ-013 SHALL be a two-state FSM: IDLE (after reset, ser_out=1, no strobes) and RUN; IDLE->RUN on the first accepted sample; RUN exits only on rst.
REQ-014 SHALL hold one-entry buffer; accept = pcm_valid && pcm_ready; pcm_ready = !buf_full || slot_load_consumes_buf.
REQ-015 SHALL, on same-cycle accept and consume, load the shift register with old buffer and keep buffer full with new sample.
REQ-016 SHALL run divider div_cnt 0..BIT_DIV-1 in RUN; bit_stb=1 and ser_out updates in the cycle div_cnt wraps to 0.
REQ-017 SHALL count bits 7..0 per slot; at bit 7 of each slot, load shift register and present its MSB.
REQ-018 SHALL load buffer contents into a data slot if buffer full, else 8'hD5 (A-law idle) with underrun pulse in that cycle.
REQ-019 SHALL wrap slot_idx NUM_SLOTS-1 -> 0 and toggle an internal frame parity bit at the wrap.
REQ-020 SHALL make first RUN bit appear 1 cycle after IDLE->RUN transition, as bit 7 of slot 0, frame parity 0.
REQ-021 SHALL never drop or duplicate an accepted sample; latency from accept to first bit of that sample bounded by one slot period plus 1 cycle.

Reset
REQ-022 SHALL on rst: state=IDLE, buffer empty, div_cnt=0, slot_idx=0, parity=0, ser_out=1, bit_stb=0, frame_sync=0, underrun=0, pcm_ready=1.
REQ-023 SHALL abort any frame mid-slot on rst; pcm_valid is ignored in the rst cycle.

Configuration
REQ-024 SHALL with macro PCM_FAS_INSERT_EN defined treat slot 0 as overhead: 8'h9B when parity 0, 8'hDF when parity 1; buffer never consumed, no underrun in slot 0.
REQ-025 SHALL without PCM_FAS_INSERT_EN treat slot 0 as an ordinary data slot.

Structure
REQ-026 SHALL place PCM_IDLE_CODE (8'hD5), FAS_WORD (8'h9B), NFAS_WORD (8'hDF) and the FSM state enum in shared package pcm_pkg.
REQ-027 SHALL contain one sub-module pcm_bit_timer (divider plus bit/slot counters, emits bit_stb, slot-load and frame-wrap pulses).

Verification
REQ-028 Reset, no valid for 100 cycles -> ser_out=1, bit_stb=0, pcm_ready=1 throughout.
REQ-029 BIT_DIV=4, NUM_SLOTS=4, no FAS, stream 8'hA5,8'h3C,... back-to-back -> ser_out 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, bit_stb every 4 cycles, no underrun.
REQ-030 FAS defined, NUM_SLOTS=4 -> slot 0 frames alternate 8'h9B, 8'hDF; frame_sync high 4 cycles per frame; slots 1..3 carry data.
REQ-031 Single sample 8'h12 then valid low -> 8'h12 shifted once, following data slots carry 8'hD5 each with one underrun pulse.
REQ-032 Valid held high with pcm_ready toggling -> each accepted value appears exactly once, in order; pcm_ready low only while buffer full and no load.
REQ-033 rst asserted at bit 3 of slot 2 -> next cycle all outputs at reset values; restart begins at slot 0 bit 7 after next accept.

Source files
------------

// File: rtl/pcm_pkg.sv
// -----------------------------------------------------------------------------
// pcm_pkg
// Shared constants and types for the PCM TDM frame transmitter.
//   PCM_IDLE_CODE : A-law idle pattern sent in a data slot with no sample.
//   FAS_WORD      : frame alignment word, slot 0 of even-parity frames.
//   NFAS_WORD     : non-alignment word, slot 0 of odd-parity frames.
//   pcm_state_e   : transmitter FSM states.
// Optional feature macro used by the block: PCM_FAS_INSERT_EN.
// -----------------------------------------------------------------------------
package pcm_pkg;

    localparam logic [7:0] PCM_IDLE_CODE = 8'hD5;
    localparam logic [7:0] FAS_WORD      = 8'h9B;
    localparam logic [7:0] NFAS_WORD     = 8'hDF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pcm_state_e;

    // Overhead word for slot 0, selected by the frame parity bit.
    function automatic logic [7:0] overhead_word(input logic parity);
        logic [7:0] word;
        if (parity) begin
            word = NFAS_WORD;
        end else begin
            word = FAS_WORD;
        end
        return word;
    endfunction

endpackage

// File: rtl/pcm_bit_timer.sv
// -----------------------------------------------------------------------------
// pcm_bit_timer
// Bit-rate divider plus bit/slot position counters for the TDM transmitter.
// The counters describe the position of the NEXT bit to be presented, so the
// parent can register its outputs on the same tick.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_start       : one-cycle pulse on the IDLE->RUN transition
//   i_run         : FSM is in RUN
//   o_bit_stb     : tick, a new bit must be presented on this edge
//   o_slot_load   : tick for bit 7 of a slot (load shift register)
//   o_frame_wrap  : tick for bit 0 of the last slot (frame ends)
//   o_slot_nxt    : slot index of the bit presented on this tick
// -----------------------------------------------------------------------------
module pcm_bit_timer
    import pcm_pkg::*;
#(
    parameter int NUM_SLOTS = 32,
    parameter int BIT_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_run,
    output logic       o_bit_stb,
    output logic       o_slot_load,
    output logic       o_frame_wrap,
    output logic [4:0] o_slot_nxt
);

    localparam int              DIV_W     = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [4:0]      SLOT_LAST = 5'(NUM_SLOTS - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_bit_nxt;
    logic [4:0]       r_slot_nxt;
    logic             w_tick;

    // Tick decode and position-derived pulses.
    always_comb begin
        w_tick       = i_run && (r_div_cnt == DIV_LAST);
        o_bit_stb    = w_tick;
        o_slot_load  = w_tick && (r_bit_nxt == 3'd7);
        o_frame_wrap = w_tick && (r_bit_nxt == 3'd0) && (r_slot_nxt == SLOT_LAST);
        o_slot_nxt   = r_slot_nxt;
    end

    // Divider and bit/slot counters. On start the divider is preloaded to its
    // last value so the first bit appears on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_bit_nxt  <= 3'd7;
            r_slot_nxt <= 5'd0;
        end else if (i_start) begin
            r_div_cnt  <= DIV_LAST;
            r_bit_nxt  <= 3'd7;
            r_slot_nxt <= 5'd0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_bit_nxt <= r_bit_nxt - 3'd1;
            if (r_bit_nxt == 3'd0) begin
                if (r_slot_nxt == SLOT_LAST) begin
                    r_slot_nxt <= 5'd0;
                end else begin
                    r_slot_nxt <= r_slot_nxt + 5'd1;
                end
            end else begin
                r_slot_nxt <= r_slot_nxt;
            end
        end else if (i_run) begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end else begin
            r_div_cnt <= '0;
        end
    end

endmodule

// File: rtl/pcm_frame_tx.sv
// -----------------------------------------------------------------------------
// pcm_frame_tx
// Serialises 8-bit companded PCM samples into a TDM frame of NUM_SLOTS slots,
// MSB first, one bit every BIT_DIV clocks. A one-entry buffer decouples the
// encoder; an empty buffer at slot start sends the A-law idle code and pulses
// underrun.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   pcm_in     : sample from encoder, taken when pcm_valid && pcm_ready
//   pcm_valid  : pcm_in valid
//   pcm_ready  : buffer can take a sample this cycle
//   ser_out    : serial TDM stream (1 while idle)
//   bit_stb    : one-cycle pulse when a new ser_out bit is presented
//   frame_sync : high during bit 7 of slot 0
//   slot_idx   : slot currently shifting
//   underrun   : one-cycle pulse when a data slot loads the idle code
// Build option: define PCM_FAS_INSERT_EN to make slot 0 an overhead slot
// carrying FAS/NFAS words on alternate frames.
// -----------------------------------------------------------------------------
module pcm_frame_tx
    import pcm_pkg::*;
#(
    parameter int NUM_SLOTS = 32,
    parameter int BIT_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pcm_in,
    input  logic       pcm_valid,
    output logic       pcm_ready,
    output logic       ser_out,
    output logic       bit_stb,
    output logic       frame_sync,
    output logic [4:0] slot_idx,
    output logic       underrun
);

    pcm_state_e r_state;
    pcm_state_e w_state_nxt;

    logic [7:0] r_buf;
    logic       r_buf_full;
    logic [6:0] r_shift;
    logic       r_parity;
    logic       r_ser_out;
    logic       r_bit_stb;
    logic       r_frame_sync;
    logic [4:0] r_slot_idx;
    logic       r_underrun;

    logic       w_accept;
    logic       w_start;
    logic       w_run;
    logic       w_tick;
    logic       w_slot_load;
    logic       w_frame_wrap;
    logic [4:0] w_slot_nxt;
    logic       w_data_slot;
    logic [7:0] w_load_word;
    logic       w_consume;
    logic       w_underrun;

    pcm_bit_timer #(
        .NUM_SLOTS (NUM_SLOTS),
        .BIT_DIV   (BIT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_run        (w_run),
        .o_bit_stb    (w_tick),
        .o_slot_load  (w_slot_load),
        .o_frame_wrap (w_frame_wrap),
        .o_slot_nxt   (w_slot_nxt)
    );

    // Slot classification and the word loaded at slot start.
    always_comb begin
`ifdef PCM_FAS_INSERT_EN
        w_data_slot = (w_slot_nxt != 5'd0);
`else
        w_data_slot = 1'b1;
`endif
        if (!w_data_slot) begin
            w_load_word = overhead_word(r_parity);
        end else if (r_buf_full) begin
            w_load_word = r_buf;
        end else begin
            w_load_word = PCM_IDLE_CODE;
        end
    end

    // Handshake. pcm_ready must see a same-cycle consume, so it is
    // combinational from registered state only (never from pcm_valid).
    always_comb begin
        w_consume  = w_slot_load && w_data_slot && r_buf_full;
        w_underrun = w_slot_load && w_data_slot && !r_buf_full;
        pcm_ready  = !r_buf_full || w_consume;
        w_accept   = pcm_valid && pcm_ready && !rst;
        w_run      = (r_state == ST_RUN);
        w_start    = (r_state == ST_IDLE) && w_accept;
    end

    // FSM next state: leave IDLE on the first accepted sample, stay in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One-entry sample buffer. Accept wins over consume, so a same-cycle
    // accept and load keeps the buffer full with the new sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= 8'h00;
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= pcm_in;
            r_buf_full <= 1'b1;
        end else if (w_consume) begin
            r_buf_full <= 1'b0;
        end else begin
            r_buf_full <= r_buf_full;
        end
    end

    // Frame parity selects FAS vs NFAS; it flips as each frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_frame_wrap) begin
            r_parity <= ~r_parity;
        end else begin
            r_parity <= r_parity;
        end
    end

    // Shift register and registered serial outputs, updated on each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= 7'h00;
            r_ser_out    <= 1'b1;
            r_bit_stb    <= 1'b0;
            r_frame_sync <= 1'b0;
            r_slot_idx   <= 5'd0;
            r_underrun   <= 1'b0;
        end else begin
            r_bit_stb  <= w_tick;
            r_underrun <= w_underrun;
            if (w_tick) begin
                if (w_slot_load) begin
                    r_shift   <= w_load_word[6:0];
                    r_ser_out <= w_load_word[7];
                end else begin
                    r_shift   <= {r_shift[5:0], 1'b0};
                    r_ser_out <= r_shift[6];
                end
                r_frame_sync <= w_slot_load && (w_slot_nxt == 5'd0);
                r_slot_idx   <= w_slot_nxt;
            end else begin
                r_shift      <= r_shift;
                r_ser_out    <= r_ser_out;
                r_frame_sync <= r_frame_sync;
                r_slot_idx   <= r_slot_idx;
            end
        end
    end

    assign ser_out    = r_ser_out;
    assign bit_stb    = r_bit_stb;
    assign frame_sync = r_frame_sync;
    assign slot_idx   = r_slot_idx;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_pcm_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_pcm_frame_tx
// Directed bench for pcm_frame_tx with NUM_SLOTS=4, BIT_DIV=4. Expected
// frame contents follow PCM_FAS_INSERT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_pcm_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] pcm_in;
    logic       pcm_valid;
    logic       pcm_ready;
    logic       ser_out;
    logic       bit_stb;
    logic       frame_sync;
    logic [4:0] slot_idx;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;

    int q_byte[$];
    int q_slot[$];
    int q_ur[$];

    int exp_s[$];
    int exp_su[$];
    int exp_1[$];
    int exp_1u[$];
    int exp_1s[$];
    int exp_restart_byte;

    pcm_frame_tx #(
        .NUM_SLOTS (4),
        .BIT_DIV   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pcm_in     (pcm_in),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .ser_out    (ser_out),
        .bit_stb    (bit_stb),
        .frame_sync (frame_sync),
        .slot_idx   (slot_idx),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Offer one sample from a negedge; return at the negedge after acceptance.
    task automatic send(input logic [7:0] v, output int waits);
        waits     = 0;
        pcm_in    = v;
        pcm_valid = 1'b1;
        while (pcm_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) begin
            check("send_timeout", 32'(waits), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic clear_q();
        q_byte.delete();
        q_slot.delete();
        q_ur.delete();
    endtask

    task automatic check_bytes(input string name, input int eb[$], input int eu[$]);
        for (int i = 0; i < eb.size(); i++) begin
            if (i < q_byte.size()) begin
                check($sformatf("%s_byte%0d", name, i), 32'(q_byte[i]), 32'(eb[i]));
                check($sformatf("%s_ur%0d", name, i), 32'(q_ur[i]), 32'(eu[i]));
                check($sformatf("%s_slot%0d", name, i), 32'(q_slot[i]), 32'(i % 4));
            end else begin
                check($sformatf("%s_missing%0d", name, i), 32'(q_byte.size()), 32'(eb.size()));
            end
        end
    endtask

    // Byte collector: reassembles slots from the serial stream.
    initial begin : collector
        int       pos;
        logic [7:0] sh;
        int       sl;
        int       ur;
        pos = 0;
        sh  = 8'h00;
        sl  = 0;
        ur  = 0;
        forever begin
            @(negedge clk);
            if (bit_stb === 1'b1) begin
                if (frame_sync === 1'b1) begin
                    pos = 0;
                end
                if (pos == 0) begin
                    sl = int'(slot_idx);
                    ur = int'(underrun);
                end
                sh = {sh[6:0], ser_out};
                pos++;
                if (pos == 8) begin
                    q_byte.push_back(int'(sh));
                    q_slot.push_back(sl);
                    q_ur.push_back(ur);
                    pos = 0;
                end
            end
        end
    end

    initial begin : main
        logic [7:0] samples [8];
        int waits [8];
        int w;
        int c_ser, c_stb, c_rdy, c_fs, c_bad, last, found;

        samples = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h00, 8'hFF, 8'h5A, 8'hC3};
`ifdef PCM_FAS_INSERT_EN
        exp_s  = '{32'h9B, 32'hA5, 32'h3C, 32'h81, 32'hDF, 32'h7E, 32'h00, 32'hFF,
                   32'h9B, 32'h5A, 32'hC3, 32'hD5};
        exp_su = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        exp_1  = '{32'h9B, 32'h12, 32'hD5, 32'hD5, 32'hDF};
        exp_1u = '{0, 0, 1, 1, 0};
        exp_restart_byte = 32'h9B;
`else
        exp_s  = '{32'hA5, 32'h3C, 32'h81, 32'h7E, 32'h00, 32'hFF, 32'h5A, 32'hC3, 32'hD5};
        exp_su = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        exp_1  = '{32'h12, 32'hD5, 32'hD5, 32'hD5, 32'hD5};
        exp_1u = '{0, 1, 1, 1, 1};
        exp_restart_byte = 32'h66;
`endif

        // Reset and idle behaviour
        rst       = 1'b1;
        pcm_valid = 1'b0;
        pcm_in    = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ser_out", 32'(ser_out), 32'd1);
        check("rst_bit_stb", 32'(bit_stb), 32'd0);
        check("rst_frame_sync", 32'(frame_sync), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_slot_idx", 32'(slot_idx), 32'd0);
        check("rst_pcm_ready", 32'(pcm_ready), 32'd1);
        c_ser = 0; c_stb = 0; c_rdy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ser_out === 1'b1) c_ser++;
            if (bit_stb === 1'b1) c_stb++;
            if (pcm_ready === 1'b1) c_rdy++;
        end
        check("idle_ser_out_high", 32'(c_ser), 32'd100);
        check("idle_no_bit_stb", 32'(c_stb), 32'd0);
        check("idle_ready_high", 32'(c_rdy), 32'd100);

        // Back-to-back stream with valid held high
        clear_q();
        for (int k = 0; k < 8; k++) begin
            send(samples[k], w);
            waits[k] = w;
        end
        pcm_valid = 1'b0;
        check("stream_wait_first", 32'(waits[0]), 32'd0);
        check("stream_wait_third", 32'(waits[2]), 32'd31);
        c_stb = 0; c_fs = 0; c_bad = 0; last = -1;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            if (bit_stb === 1'b1) begin
                c_stb++;
                if (last >= 0 && (c - last) != 4) c_bad++;
                last = c;
            end
            if (frame_sync === 1'b1) c_fs++;
        end
        check("stream_stb_count", 32'(c_stb), 32'd64);
        check("stream_stb_spacing", 32'(c_bad), 32'd0);
        check("stream_fsync_cycles", 32'(c_fs), 32'd8);
        repeat (100) @(negedge clk);
        check_bytes("stream", exp_s, exp_su);

        // Single sample then underrun
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        send(8'h12, w);
        pcm_valid = 1'b0;
        repeat (200) @(negedge clk);
        check_bytes("single", exp_1, exp_1u);

        // Reset at bit 3 of slot 2, valid high in the reset cycle
        found = 0;
        c_stb = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            @(negedge clk);
            if (bit_stb === 1'b1 && slot_idx == 5'd2) begin
                c_stb++;
                if (c_stb == 5) found = 1;
            end
        end
        check("slot2_bit3_found", 32'(found), 32'd1);
        rst       = 1'b1;
        pcm_valid = 1'b1;
        pcm_in    = 8'hEE;
        @(negedge clk);
        rst       = 1'b0;
        pcm_valid = 1'b0;
        check("midrst_ser_out", 32'(ser_out), 32'd1);
        check("midrst_bit_stb", 32'(bit_stb), 32'd0);
        check("midrst_frame_sync", 32'(frame_sync), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        check("midrst_slot_idx", 32'(slot_idx), 32'd0);
        check("midrst_pcm_ready", 32'(pcm_ready), 32'd1);
        c_ser = 0; c_stb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ser_out === 1'b1) c_ser++;
            if (bit_stb === 1'b1) c_stb++;
        end
        check("midrst_idle_ser", 32'(c_ser), 32'd20);
        check("midrst_idle_stb", 32'(c_stb), 32'd0);

        // Restart: first bit one cycle after the transition
        clear_q();
        send(8'h66, w);
        pcm_valid = 1'b0;
        check("restart_no_stb_yet", 32'(bit_stb), 32'd0);
        @(negedge clk);
        check("restart_first_stb", 32'(bit_stb), 32'd1);
        check("restart_frame_sync", 32'(frame_sync), 32'd1);
        check("restart_slot0", 32'(slot_idx), 32'd0);
        check("restart_msb", 32'(ser_out), 32'(exp_restart_byte[7]));
        repeat (40) @(negedge clk);
        if (q_byte.size() > 0) begin
            check("restart_byte", 32'(q_byte[0]), 32'(exp_restart_byte));
        end else begin
            check("restart_byte_missing", 32'(q_byte.size()), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
